// File: rtl/uart_mmio_ctrl.sv
// MMIO bridge between the MIPS150 MEM stage and the UART: TX FIFO, RX holding register, cycle counter.
// Optional feature macro: MMIO_CYCLE_COUNTER_EN (builds the CYCLE register at offset 0x10).
module uart_mmio_ctrl #(
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);

    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CW = $clog2(TX_DEPTH + 1);

    localparam logic [5:0] OFF_TXSTAT = 6'd0;
    localparam logic [5:0] OFF_RXSTAT = 6'd1;
    localparam logic [5:0] OFF_TXDATA = 6'd2;
    localparam logic [5:0] OFF_RXDATA = 6'd3;
    localparam logic [5:0] OFF_CYCLE  = 6'd4;

    logic          sel;
    logic [5:0]    off;
    logic          wr_en;
    logic          rd_en;
    logic [7:0]    mem [TX_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          full;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;
    logic          tx_drop;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ovf;
    logic          rx_pop;
    logic [31:0]   cyc_val;
    logic [31:0]   rd_val;
    logic          unused_bits;

    assign sel   = (cpu_addr[31:28] == 4'h8);
    assign off   = cpu_addr[7:2];
    assign wr_en = cpu_we & sel;
    // a simultaneous store suppresses the load entirely
    assign rd_en = cpu_re & ~cpu_we & sel;

    assign unused_bits = ^{cpu_wdata[31:8], cpu_addr[27:8], cpu_addr[1:0]};

    assign full           = (count == CW'(TX_DEPTH));
    assign uart_din_valid = (count != '0);
    assign uart_din       = mem[head];
    assign uart_dout_ready = 1'b1;

    assign pop      = uart_din_valid & uart_din_ready;
    assign push_req = wr_en & (off == OFF_TXDATA);
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign rx_pop   = rd_en & (off == OFF_RXDATA) & rx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                mem[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            tx_drop <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= cpu_wdata[7:0];
                tail      <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                tx_drop <= 1'b1;
            end else if (wr_en && off == OFF_TXSTAT) begin
                tx_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ovf   <= 1'b0;
        end else begin
            if (uart_dout_valid) begin
                rx_data  <= uart_dout;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_pop) begin
                    rx_ovf <= 1'b1;
                end else if (wr_en && off == OFF_RXSTAT) begin
                    rx_ovf <= 1'b0;
                end
            end else begin
                if (rx_pop) begin
                    rx_valid <= 1'b0;
                end
                if (wr_en && off == OFF_RXSTAT) begin
                    rx_ovf <= 1'b0;
                end
            end
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cycle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle <= '0;
        end else if (wr_en && off == OFF_CYCLE) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    assign cyc_val = cycle;
`else
    assign cyc_val = '0;
`endif

    always_comb begin
        rd_val = '0;
        if (rd_en) begin
            case (off)
                OFF_TXSTAT: rd_val = {30'd0, tx_drop, ~full};
                OFF_RXSTAT: rd_val = {30'd0, rx_ovf, rx_valid};
                OFF_RXDATA: rd_val = rx_valid ? {24'd0, rx_data} : 32'd0;
                OFF_CYCLE:  rd_val = cyc_val;
                default:    rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
        end else if (cpu_re) begin
            cpu_rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Testbench for uart_mmio_ctrl: directed plan plus randomized traffic against a queue-based model.
module tb_uart_mmio_ctrl;

    localparam int TXD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic [7:0]  uart_din;
    logic        uart_din_valid;
    logic        uart_din_ready = 1'b0;
    logic [7:0]  uart_dout = '0;
    logic        uart_dout_valid = 1'b0;
    logic        uart_dout_ready;

    int passed = 0;
    int total = 0;

    logic [7:0]  txq[$];
    logic        tx_drop = 1'b0;
    logic        rxv = 1'b0;
    logic [7:0]  rxd = '0;
    logic        rxo = 1'b0;
    logic [31:0] cyc = '0;
    logic        rdy_g = 1'b0;

    uart_mmio_ctrl #(.TX_DEPTH(TXD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we),
        .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata),
        .uart_din(uart_din),
        .uart_din_valid(uart_din_valid),
        .uart_din_ready(uart_din_ready),
        .uart_dout(uart_dout),
        .uart_dout_valid(uart_dout_valid),
        .uart_dout_ready(uart_dout_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mread(input int off);
        case (off)
            0: return {30'd0, tx_drop, logic'(txq.size() != TXD)};
            1: return {30'd0, rxo, rxv};
            3: return rxv ? {24'd0, rxd} : 32'd0;
`ifdef MMIO_CYCLE_COUNTER_EN
            4: return cyc;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        txq.delete();
        tx_drop = 1'b0;
        rxv = 1'b0;
        rxd = '0;
        rxo = 1'b0;
        cyc = '0;
    endtask

    task automatic step(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wd, input logic rdy, input logic dv,
                        input logic [7:0] dd);
        logic [31:0] exp;
        bit io;
        bit pop;
        bit rxpop;
        int off;
        cpu_we = we;
        cpu_re = re;
        cpu_addr = addr;
        cpu_wdata = wd;
        uart_din_ready = rdy;
        uart_dout_valid = dv;
        uart_dout = dd;
        io = (addr[31:28] == 4'h8);
        off = int'(addr[7:2]);
        exp = (re && !we && io) ? mread(off) : 32'd0;
        pop = rdy && (txq.size() != 0);
        rxpop = re && !we && io && off == 3 && rxv;
        @(posedge clk);
        #1;
        if (pop) void'(txq.pop_front());
        if (we && io && off == 2) begin
            if (txq.size() == TXD) tx_drop = 1'b1;
            else txq.push_back(wd[7:0]);
        end
        if (we && io && off == 0) tx_drop = 1'b0;
        if (we && io && off == 1) rxo = 1'b0;
        if (dv) begin
            if (rxv && !rxpop) rxo = 1'b1;
            rxd = dd;
            rxv = 1'b1;
        end else if (rxpop) begin
            rxv = 1'b0;
        end
        if (we && io && off == 4) cyc = '0;
        else cyc = cyc + 32'd1;
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        uart_dout_valid = 1'b0;
        chk("din_valid", {31'd0, uart_din_valid}, {31'd0, logic'(txq.size() != 0)});
        if (txq.size() != 0) chk("din", {24'd0, uart_din}, {24'd0, txq[0]});
        if (re) chk("rdata", cpu_rdata, exp);
        chk("dout_ready", {31'd0, uart_dout_ready}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d, rdy_g, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 1'b1, a, 32'd0, rdy_g, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, rdy_g, 1'b0, 8'h00);
    endtask

    task automatic rx(input logic [7:0] b);
        step(1'b0, 1'b0, 32'd0, 32'd0, rdy_g, 1'b1, b);
    endtask

    initial begin
        logic [7:0] seq1 [4];
        logic [7:0] seq2 [4];
        seq1 = '{8'h41, 8'h42, 8'h43, 8'h44};
        seq2 = '{8'h52, 8'h53, 8'h54, 8'h55};

        #2;
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_valid", {31'd0, uart_din_valid}, 32'd0);
        chk("rst_din", {24'd0, uart_din}, 32'd0);
        chk("rst_dout_ready", {31'd0, uart_dout_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        rdy_g = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h8000_0008, {24'd0, seq1[i]});
        rd(32'h8000_0000);
        chk("txstat_full", cpu_rdata, 32'h0);
        wr(32'h8000_0008, 32'h45);
        rd(32'h8000_0000);
        chk("txstat_drop", cpu_rdata, 32'h2);
        rdy_g = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_order", {24'd0, uart_din}, {24'd0, seq1[i]});
            idle();
        end
        chk("tx_drained", {31'd0, uart_din_valid}, 32'd0);
        rd(32'h8000_0000);
        chk("txstat_empty", cpu_rdata, 32'h3);

        wr(32'h8000_0000, 32'd0);
        rdy_g = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h8000_0008, 32'h51 + i);
        rdy_g = 1'b1;
        wr(32'h8000_0008, 32'h55);
        rdy_g = 1'b0;
        rd(32'h8000_0000);
        chk("full_push_pop", cpu_rdata, 32'h0);
        rdy_g = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_order2", {24'd0, uart_din}, {24'd0, seq2[i]});
            idle();
        end

        rx(8'h5A);
        rd(32'h8000_0004);
        chk("rxstat_v", cpu_rdata, 32'h1);
        rd(32'h8000_000C);
        chk("rxdata", cpu_rdata, 32'h5A);
        rd(32'h8000_0004);
        chk("rxstat_pop", cpu_rdata, 32'h0);
        rd(32'h8000_000C);
        chk("rxdata_empty", cpu_rdata, 32'h0);

        rx(8'h11);
        rx(8'h22);
        rd(32'h8000_0004);
        chk("rxstat_ovf", cpu_rdata, 32'h3);
        wr(32'h8000_0004, 32'd0);
        rd(32'h8000_0004);
        chk("rxstat_clr", cpu_rdata, 32'h1);
        rd(32'h8000_000C);
        chk("rxdata_ovw", cpu_rdata, 32'h22);

        rx(8'h33);
        step(1'b0, 1'b1, 32'h8000_000C, 32'd0, rdy_g, 1'b1, 8'h44);
        chk("rx_pop_arrive", cpu_rdata, 32'h33);
        rd(32'h8000_0004);
        chk("rx_no_ovf", cpu_rdata, 32'h1);
        rd(32'h8000_000C);
        chk("rx_new", cpu_rdata, 32'h44);

        wr(32'h8000_0010, 32'd0);
        repeat (10) idle();
        rd(32'h8000_0010);
`ifdef MMIO_CYCLE_COUNTER_EN
        chk("cycle", cpu_rdata, 32'h0A);
`else
        chk("cycle", cpu_rdata, 32'h0);
`endif

        rd(32'h8000_0000);
        chk("rd_pre_both", cpu_rdata, 32'h1);
        step(1'b1, 1'b1, 32'h8000_0000, 32'd0, rdy_g, 1'b0, 8'h00);
        chk("we_re_both", cpu_rdata, 32'h0);

        for (int n = 0; n < 400; n++) begin
            int offs [7];
            logic [3:0] hi;
            logic [31:0] a;
            offs = '{0, 1, 2, 3, 4, 5, 63};
            hi = ($urandom_range(0, 7) == 0) ? 4'h3 : 4'h8;
            a = {hi, 20'($urandom), 6'(offs[$urandom_range(0, 6)]), 2'($urandom)};
            step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 1)), a,
                 $urandom, logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 4) == 0), 8'($urandom));
        end

        rdy_g = 1'b0;
        wr(32'h8000_0000, 32'd0);
        wr(32'h8000_0008, 32'h99);
        rd(32'h8000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, uart_din_valid}, 32'd0);
        chk("arst_rdata", cpu_rdata, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        rd(32'h8000_0000);
        chk("post_rst_txstat", cpu_rdata, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
